// File: rtl/rnm_sar_adc.sv
// Real-number-model SAR ADC sitting behind the RNM amplifier.
// It samples vin on a start request and resolves one bit per clock,
// using vdd as the +/- full-scale reference.
// The result is an offset-binary code with a one-cycle valid strobe.
//
//   state  | meaning
//   IDLE   | waiting for an accepted start request
//   CONV   | bit k of res under trial against the held sample
`timescale 1ns/1ps

module rnm_sar_adc #(
  parameter int  N    = 8,
  parameter real VMIN = 0.5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         start,
  input  real          vin,
  input  real          vdd,
  output logic [N-1:0] code,
  output logic         valid,
  output logic         busy,
  output logic         ovr
);

  localparam int           KW     = (N > 2) ? $clog2(N) : 1;
  localparam logic [0:0]   S_IDLE = 1'b0;
  localparam logic [0:0]   S_CONV = 1'b1;
  localparam logic [KW-1:0] K_TOP = KW'(N - 1);
  localparam logic [N-1:0] ONE    = N'(1);
  localparam real          HALF   = real'(2 ** (N - 1));

  logic [0:0]    state;
  logic [KW-1:0] k;
  logic [N-1:0]  res;
  real           vs;
  real           vref;

  logic [N-1:0]  trial;
  logic [N-1:0]  res_next;
  real           th;
  logic          keep_bit;
  logic          sup_ok;
  logic          out_of_range;

  // Trial threshold for the bit under test; equality keeps the bit.
  always_comb begin
    trial        = res | (ONE << k);
    th           = (real'(trial) - HALF) * vref / HALF;
    keep_bit     = (vs >= th);
    res_next     = keep_bit ? trial : res;
    sup_ok       = (vdd >= VMIN);
    out_of_range = (vs >= vref) || (vs < -vref);
  end

  // Conversion sequencer: sample-and-hold, bit decisions, abort and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      code  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      ovr   <= 1'b0;
      vs    <= 0.0;
      vref  <= 0.0;
      res   <= '0;
      k     <= K_TOP;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && en && sup_ok) begin
            vs    <= vin;
            vref  <= vdd;
            res   <= '0;
            k     <= K_TOP;
            busy  <= 1'b1;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          // Losing enable or supply abandons the conversion; last result is kept.
          if (!en || !sup_ok) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            res <= res_next;
            if (k == '0) begin
              code  <= res_next;
              ovr   <= out_of_range;
              valid <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              k <= k - 1'b1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rnm_sar_adc.sv
// Directed self-checking bench for rnm_sar_adc (N=8, VMIN=0.5).
`timescale 1ns/1ps

module tb_rnm_sar_adc;

  logic       clk;
  logic       rst;
  logic       en;
  logic       start;
  real        vin;
  real        vdd;
  logic [7:0] code;
  logic       valid;
  logic       busy;
  logic       ovr;

  int errors = 0;
  int checks = 0;

  rnm_sar_adc #(.N(8), .VMIN(0.5)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .vin   (vin),
    .vdd   (vdd),
    .code  (code),
    .valid (valid),
    .busy  (busy),
    .ovr   (ovr)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Transfer function written directly from the closed-form definition.
  function automatic logic [7:0] model_code(input real v, input real r);
    real x;
    int  f;
    logic [31:0] fv;
    x = v / r * 128.0;
    f = int'($floor(x)) + 128;
    if (f < 0)   f = 0;
    if (f > 255) f = 255;
    fv = 32'(f);
    return fv[7:0];
  endfunction

  // One conversion from a start pulse; vin is disturbed right after sampling.
  task automatic run_conv(input real v, output logic [7:0] c, output logic o,
                          output int lat, output int bcnt, output bit both);
    vin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    vin   = 0.77;
    bcnt  = int'(busy);
    both  = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (valid && busy) both = 1'b1;
      if (valid) begin
        lat = i;
        break;
      end
      bcnt += int'(busy);
    end
    c = code;
    o = ovr;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; start = 1'b0; vin = 0.0; vdd = 1.0;
    tick(); tick();
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL reset_code got=%h want=00", code); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b want=0", ovr); end
    rst = 1'b0;
    en  = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [7:0] c; logic o; int lat; int bcnt; bit both;
    run_conv(0.0, c, o, lat, bcnt, both);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got=%0d want=8", lat); end
    checks++; if (bcnt !== 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=8", bcnt); end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL basic_valid_and_busy got=%b want=0", both); end
    checks++; if (c !== 8'h80) begin errors++; $display("FAIL basic_code got=%h want=80", c); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovr got=%b want=0", o); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_width got=%b want=0", valid); end
  endtask

  task automatic test_range;
    real        tv[6] = '{0.5, -0.25, 0.999, -1.0, 1.2, -1.5};
    logic [7:0] tc[6] = '{8'hC0, 8'h60, 8'hFF, 8'h00, 8'hFF, 8'h00};
    logic       to[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] c; logic o; int lat; int bcnt; bit both;
    for (int i = 0; i < 6; i++) begin
      run_conv(tv[i], c, o, lat, bcnt, both);
      checks++; if (lat !== 8) begin errors++; $display("FAIL range_latency[%0d] got=%0d want=8", i, lat); end
      checks++; if (c !== tc[i]) begin errors++; $display("FAIL range_code[%0d] vin=%f got=%h want=%h", i, tv[i], c, tc[i]); end
      checks++; if (o !== to[i]) begin errors++; $display("FAIL range_ovr[%0d] vin=%f got=%b want=%b", i, tv[i], o, to[i]); end
    end
    tick();
  endtask

  task automatic test_stream;
    logic [7:0] exp_c;
    exp_c = 8'h00;
    for (int c = 0; c < 45; c++) begin
      vin   = 0.8 * $sin(6.283185307 * $realtime / 10.0);
      start = 1'b1;
      if (c % 9 == 0) exp_c = model_code(vin, 1.0);
      tick();
      if (c % 9 == 8) begin
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stream_valid c=%0d got=%b want=1", c, valid); end
        checks++; if (code !== exp_c) begin errors++; $display("FAIL stream_code c=%0d got=%h want=%h", c, code, exp_c); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy c=%0d got=%b want=0", c, busy); end
      end else begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_extra_valid c=%0d got=%b want=0", c, valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy c=%0d got=%b want=1", c, busy); end
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_abort;
    logic [7:0] c; logic o; int lat; int bcnt; bit both; int vcnt;
    run_conv(1.2, c, o, lat, bcnt, both);
    checks++; if (c !== 8'hFF) begin errors++; $display("FAIL abort_pre_code got=%h want=ff", c); end
    for (int pass = 0; pass < 2; pass++) begin
      vin = -0.5; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      if (pass == 0) en = 1'b0; else vdd = 0.3;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy[%0d] got=%b want=0", pass, busy); end
      vcnt = 0;
      for (int i = 0; i < 12; i++) begin
        if (valid) vcnt++;
        tick();
      end
      checks++; if (vcnt !== 0) begin errors++; $display("FAIL abort_valid[%0d] got=%0d want=0", pass, vcnt); end
      checks++; if (code !== 8'hFF) begin errors++; $display("FAIL abort_code_hold[%0d] got=%h want=ff", pass, code); end
      checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL abort_ovr_hold[%0d] got=%b want=1", pass, ovr); end
      en = 1'b1; vdd = 1.0;
      tick();
    end
  endtask

  task automatic test_supply_and_reset;
    logic [7:0] c; logic o; int lat; int bcnt; bit both; int bseen; int found;
    vdd = 0.0; start = 1'b1; bseen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy) bseen++;
    end
    start = 1'b0; vdd = 1.0;
    checks++; if (bseen !== 0) begin errors++; $display("FAIL low_vdd_busy got=%0d want=0", bseen); end
    tick();
    run_conv(1.2, c, o, lat, bcnt, both);
    vin = 0.5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL midrst_code got=%h want=00", code); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL midrst_ovr got=%b want=0", ovr); end
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL postrst_accept got=%b want=1", busy); end
    found = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (valid) begin
        found = i;
        break;
      end
    end
    checks++; if (found !== 8) begin errors++; $display("FAIL postrst_latency got=%0d want=8", found); end
    checks++; if (code !== 8'hC0) begin errors++; $display("FAIL postrst_code got=%h want=c0", code); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_stream();
    test_abort();
    test_supply_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
